// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package adder_tree_pkg;

  // Default geometry: a 4-input, 16-bit tree feeding a 24-bit accumulator.
  localparam int DATA_W_DEF = 16;
  localparam int NUM_IN_DEF = 4;
  localparam int ACC_W_DEF  = 24;

  // Ceiling log2, usable in constant expressions (parameter derivation).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One level of the adder tree: M operands of width W are summed in adjacent
// pairs into M/2 registered results of width W+1. The one-bit growth means
// no pair add can overflow, so no truncation or saturation is needed.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int W      = 16,
  parameter int M      = 4,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [M*W-1:0]             din,
  output logic [(M/2)*(W+1)-1:0]     dout
);

  localparam int PAIRS = M / 2;

  // Widen one operand by a single bit: sign-extend for two's-complement
  // operation, zero-extend otherwise.
  function automatic logic [W:0] ext_op(input logic [W-1:0] op);
    logic signed [W:0] op_s;
    if (SIGNED != 0) begin
      op_s = (W+1)'($signed(op));
      return op_s;
    end else begin
      return {1'b0, op};
    end
  endfunction

  logic [PAIRS*(W+1)-1:0] pair_sum;
  logic [PAIRS*(W+1)-1:0] sum_p1;

  // Combinational pair adds for this level.
  always_comb begin
    pair_sum = '0;
    for (int k = 0; k < PAIRS; k++) begin
      pair_sum[k*(W+1) +: (W+1)] = ext_op(din[(2*k)*W +: W])
                                 + ext_op(din[(2*k+1)*W +: W]);
    end
  end

  // ---- stage boundary: pair sums registered every cycle ----
  // Data loads unconditionally; reset clears it so sum never carries X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
    end else begin
      sum_p1 <= pair_sum;
    end
  end

  assign dout = sum_p1;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_IN-input adder tree with a valid qualifier and a running
// accumulator. One register stage per tree level gives LVL cycles of latency
// at one sample per clock; the accumulator adds each qualified sum one cycle
// after it appears on the output and keeps a sticky overflow flag.
// NUM_IN must be a power of two >= 2 and ACC_W must be >= SUM_W.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_IN = NUM_IN_DEF,
  parameter  int ACC_W  = ACC_W_DEF,
  parameter  int SIGNED = 0,
  localparam int LVL    = clog2(NUM_IN),
  localparam int SUM_W  = DATA_W + LVL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  output logic [SUM_W-1:0]         sum,
  output logic [ACC_W-1:0]         acc,
  output logic                     acc_ovf
);

  // Extend a tree sum to accumulator width, matching operand signedness.
  function automatic logic [ACC_W-1:0] ext_sum(input logic [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] s_s;
    logic signed [ACC_W-1:0] r_s;
    if (SIGNED != 0) begin
      s_s = $signed(s);
      r_s = ACC_W'(s_s);
      return r_s;
    end else begin
      return ACC_W'(s);
    end
  endfunction

  // Overflow of the accumulator add. Unsigned: carry out of the top bit.
  // Signed: operands agree in sign but the wrapped result does not.
  function automatic logic ovf_detect(input logic [ACC_W-1:0] a,
                                      input logic [ACC_W-1:0] b,
                                      input logic [ACC_W:0]   r);
    if (SIGNED != 0) begin
      return (a[ACC_W-1] == b[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
    end else begin
      return r[ACC_W];
    end
  endfunction

  // Tree levels. Level i consumes NUM_IN>>(i-1) operands of width
  // DATA_W+i-1 from the previous level (or in_data for level 1) and
  // registers half as many results one bit wider.
  for (genvar i = 1; i <= LVL; i++) begin : g_lvl
    localparam int LW = DATA_W + i - 1;
    localparam int LM = NUM_IN >> (i - 1);

    logic [LM*LW-1:0]         lvl_in;
    logic [(LM/2)*(LW+1)-1:0] lvl_out;

    if (i == 1) begin : g_src
      assign lvl_in = in_data;
    end else begin : g_src
      assign lvl_in = g_lvl[i-1].lvl_out;
    end

    adder_tree_level #(
      .W      (LW),
      .M      (LM),
      .SIGNED (SIGNED)
    ) u_level (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (lvl_in),
      .dout  (lvl_out)
    );
  end

  assign sum = g_lvl[LVL].lvl_out;

  // Valid pipe: bit k travels alongside tree level k+1.
  logic [LVL-1:0] vld_p;

  // ---- stage boundary: valid shifts with the tree, one flop per level ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < LVL; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign out_valid = vld_p[LVL-1];

  // Accumulator datapath.
  logic             acc_take;
  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   acc_add;
  logic             add_ovf;

  // Extended sum, carry-preserving add and overflow of that add.
  always_comb begin
    acc_take = out_valid & acc_en;
    addend   = ext_sum(sum);
    acc_add  = {1'b0, acc} + {1'b0, addend};
    add_ovf  = ovf_detect(acc, addend, acc_add);
  end

  // ---- stage boundary: accumulator lags the qualified sum by one cycle ----
  // A clear coinciding with a qualified sum restarts from that sum, so no
  // sample is lost at a clear boundary. The overflow flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (acc_clr) begin
      acc     <= acc_take ? addend : '0;
      acc_ovf <= 1'b0;
    end else if (acc_take) begin
      acc <= acc_add[ACC_W-1:0];
      if (add_ovf) begin
        acc_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: three instances (default unsigned, signed,
// 8x8-bit) share clock and reset. Expected sums are queued as samples are
// driven and popped by per-instance monitors when out_valid appears.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // u0: defaults (4 x 16-bit, ACC_W 24, unsigned)
  logic        v0, en0, clr0, ov0, f0;
  logic [63:0] d0;
  logic [17:0] s0;
  logic [23:0] a0;
  // u1: signed variant
  logic        v1, en1, clr1, ov1, f1;
  logic [63:0] d1;
  logic [17:0] s1;
  logic [23:0] a1;
  // u2: 8 x 8-bit, ACC_W 16
  logic        v2, en2, clr2, ov2, f2;
  logic [63:0] d2;
  logic [10:0] s2;
  logic [15:0] a2;

  adder_tree_pipe u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .acc_en(en0),
    .acc_clr(clr0), .out_valid(ov0), .sum(s0), .acc(a0), .acc_ovf(f0)
  );

  adder_tree_pipe #(.SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .acc_en(en1),
    .acc_clr(clr1), .out_valid(ov1), .sum(s1), .acc(a1), .acc_ovf(f1)
  );

  adder_tree_pipe #(.DATA_W(8), .NUM_IN(8), .ACC_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .acc_en(en2),
    .acc_clr(clr2), .out_valid(ov2), .sum(s2), .acc(a2), .acc_ovf(f2)
  );

  int checks   = 0;
  int failures = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [10:0] q2[$];

  typedef struct {
    logic [63:0] data;
    logic [17:0] exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rep16(input logic [15:0] x);
    return {4{x}};
  endfunction

  // Scoreboard monitors: every out_valid must match the oldest queued sum.
  always @(negedge clk) begin
    if (rst_n && ov0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_unexpected_valid: actual sum=%0d required no out_valid", s0);
      end else begin
        check("u0_sum", s0, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_valid: actual sum=%0d required no out_valid", s1);
      end else begin
        check("u1_sum", s1, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL u2_unexpected_valid: actual sum=%0d required no out_valid", s2);
      end else begin
        check("u2_sum", s2, q2.pop_front());
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rep16(16'd1111), 18'd4444};
    vecs[1] = '{rep16(16'd3333), 18'd13332};
    vecs[2] = '{rep16(16'd5555), 18'd22220};
    vecs[3] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 18'd10};
    vecs[4] = '{{16'd65535, 16'd0, 16'd65535, 16'd0}, 18'd131070};
    vecs[5] = '{{16'd40000, 16'd30000, 16'd20000, 16'd10000}, 18'd100000};
    vecs[6] = '{64'd0, 18'd0};

    rst_n = 1'b0;
    v0 = 0; en0 = 0; clr0 = 0; d0 = '0;
    v1 = 0; en1 = 0; clr1 = 0; d1 = '0;
    v2 = 0; en2 = 0; clr2 = 0; d2 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_u0_valid", ov0, 0);
    check("rst_u0_sum",   s0,  0);
    check("rst_u0_acc",   a0,  0);
    check("rst_u0_ovf",   f0,  0);
    check("rst_u2_sum",   s2,  0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_u0_valid", ov0, 0);

    // Single sample: out_valid exactly two cycles after it is sampled
    v0 = 1; d0 = rep16(16'd1111); q0.push_back(18'd4444);
    @(negedge clk);
    v0 = 0;
    check("lat_t0", ov0, 0);
    @(negedge clk);
    check("lat_t1", ov0, 1);
    @(negedge clk);
    check("lat_t2", ov0, 0);

    // Back-to-back table of vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v0 = 1; d0 = vecs[i].data; q0.push_back(vecs[i].exp_sum);
    end
    @(negedge clk);
    v0 = 0;
    repeat (4) @(negedge clk);
    check("u0_table_drain", q0.size(), 0);

    // 64 full-scale samples fill the accumulator without overflow
    en0 = 1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      v0 = 1; d0 = rep16(16'hFFFF); q0.push_back(18'h3FFFC);
    end
    @(negedge clk);
    v0 = 0;
    repeat (2) @(negedge clk);
    check("acc64_val", a0, 24'd16776960);
    check("acc64_ovf", f0, 0);

    // 65th sample wraps and sets the sticky flag
    v0 = 1; d0 = rep16(16'hFFFF); q0.push_back(18'h3FFFC);
    @(negedge clk);
    v0 = 0;
    repeat (2) @(negedge clk);
    check("acc65_val", a0, 24'd261884);
    check("acc65_ovf", f0, 1);
    @(negedge clk);
    check("acc65_ovf_sticky", f0, 1);

    // Plain clear
    clr0 = 1;
    @(negedge clk);
    clr0 = 0;
    check("clr_val", a0, 0);
    check("clr_ovf", f0, 0);

    // Load 9999, then clear coinciding with a qualified 4444 sum
    v0 = 1; d0 = {48'd0, 16'd9999}; q0.push_back(18'd9999);
    @(negedge clk);
    v0 = 0;
    repeat (2) @(negedge clk);
    check("acc_9999", a0, 24'd9999);
    v0 = 1; d0 = rep16(16'd1111); q0.push_back(18'd4444);
    @(negedge clk);
    v0 = 0;
    @(negedge clk);
    check("clrsum_valid", ov0, 1);
    clr0 = 1;
    @(negedge clk);
    clr0 = 0;
    check("clrsum_val", a0, 24'd4444);
    check("clrsum_ovf", f0, 0);

    // Signed: two -4 sums accumulate to -8 without overflow
    en1 = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v1 = 1; d1 = rep16(16'hFFFF); q1.push_back(18'h3FFFC);
    end
    @(negedge clk);
    v1 = 0;
    repeat (2) @(negedge clk);
    check("s_acc_neg8", a1, 24'hFFFFF8);
    check("s_ovf_neg8", f1, 0);
    clr1 = 1;
    @(negedge clk);
    clr1 = 0;
    check("s_clr", a1, 0);

    // Signed positive overflow: 64 x 131068 fits, the 65th crosses 2^23
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      v1 = 1; d1 = rep16(16'h7FFF); q1.push_back(18'h1FFFC);
    end
    @(negedge clk);
    v1 = 0;
    repeat (2) @(negedge clk);
    check("s_acc64_val", a1, 24'd8388352);
    check("s_acc64_ovf", f1, 0);
    v1 = 1; d1 = rep16(16'h7FFF); q1.push_back(18'h1FFFC);
    @(negedge clk);
    v1 = 0;
    repeat (2) @(negedge clk);
    check("s_acc65_val", a1, 24'd8519420);
    check("s_acc65_ovf", f1, 1);

    // 8 x 8-bit instance: three cycles of latency
    en2 = 1;
    v2 = 1; d2 = {8{8'hFF}}; q2.push_back(11'd2040);
    @(negedge clk);
    v2 = 0;
    check("w8_t0", ov2, 0);
    @(negedge clk);
    check("w8_t1", ov2, 0);
    @(negedge clk);
    check("w8_t2", ov2, 1);
    check("w8_sum", s2, 11'd2040);
    @(negedge clk);
    check("w8_t3", ov2, 0);
    check("w8_acc", a2, 16'd2040);

    // Reset with two samples in flight
    v0 = 1; d0 = rep16(16'd7);
    @(negedge clk);
    d0 = rep16(16'd9);
    @(posedge clk);
    #1;
    check("pre_rst_valid", ov0, 1);
    v0 = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov0, 0);
    check("mid_rst_sum",   s0,  0);
    check("mid_rst_acc",   a0,  0);
    check("mid_rst_ovf",   f0,  0);
    check("mid_rst_acc1",  a1,  0);
    check("mid_rst_ovf1",  f1,  0);
    check("mid_rst_acc2",  a2,  0);
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", ov0, 0);
    end

    // New input after reset flows normally
    v0 = 1; d0 = rep16(16'd2); q0.push_back(18'd8);
    @(negedge clk);
    v0 = 0;
    repeat (3) @(negedge clk);
    check("final_q0", q0.size(), 0);
    check("final_q1", q1.size(), 0);
    check("final_q2", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
